// File: rtl/seq_stream_loader.sv
// Sequence-RAM writer: encodes an ASCII nucleotide byte stream to 3-bit symbols, fills A then B.
// Build option: define SEQ_LOADER_LOWERCASE_EN to also accept lowercase a/c/g/t.
module seq_stream_loader #(
  parameter int N       = 128,
  parameter int BitAddr = $clog2(N + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic [2:0]         din_ram,
  output logic               en_ram,
  output logic               weA,
  output logic               weB,
  output logic [BitAddr:0]   addr_dinA,
  output logic [BitAddr:0]   addr_dinB,
  output logic [BitAddr:0]   lenA,
  output logic [BitAddr:0]   lenB,
  output logic               load_done,
  output logic               load_err
);

  // state  | meaning
  // IDLE   | waiting for start, nothing accepted
  // LOAD_A | accepting bytes into sequence A
  // LOAD_B | accepting bytes into sequence B
  // DONE   | both sequences stored, load_done raised
  // ERR    | load aborted, lengths kept for diagnosis
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, DONE, ERR} state_t;

  localparam logic [BitAddr:0] LenMax = (BitAddr + 1)'(N);
  localparam logic [BitAddr:0] LenOne = (BitAddr + 1)'(1);

  state_t             state_q;
  logic               rx_ready_q;
  logic [2:0]         din_ram_q;
  logic               en_ram_q;
  logic               weA_q;
  logic               weB_q;
  logic [BitAddr:0]   addr_a_q;
  logic [BitAddr:0]   addr_b_q;
  logic [BitAddr:0]   lenA_q;
  logic [BitAddr:0]   lenB_q;
  logic               load_done_q;
  logic               load_err_q;

  logic [2:0]         sym_d;
  logic               is_term_d;
  logic               is_cr_d;
  logic               accept_d;
  logic               sel_b_d;
  logic [BitAddr:0]   len_cur_d;
  logic [BitAddr:0]   len_inc_d;

  // 3'b000 doubles as "not a symbol"; it is reserved as the gap code downstream.
  always_comb begin
    sym_d = 3'b000;
    case (rx_data)
      8'h41:   sym_d = 3'b001;
      8'h43:   sym_d = 3'b010;
      8'h47:   sym_d = 3'b011;
      8'h54:   sym_d = 3'b100;
`ifdef SEQ_LOADER_LOWERCASE_EN
      8'h61:   sym_d = 3'b001;
      8'h63:   sym_d = 3'b010;
      8'h67:   sym_d = 3'b011;
      8'h74:   sym_d = 3'b100;
`endif
      default: sym_d = 3'b000;
    endcase
  end

  assign is_term_d = (rx_data == 8'h0A) || (rx_data == 8'h3B);
  assign is_cr_d   = (rx_data == 8'h0D);
  assign accept_d  = rx_valid && rx_ready_q;
  assign sel_b_d   = (state_q == LOAD_B);
  assign len_cur_d = sel_b_d ? lenB_q : lenA_q;
  assign len_inc_d = len_cur_d + LenOne;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      rx_ready_q  <= 1'b0;
      din_ram_q   <= 3'b000;
      en_ram_q    <= 1'b0;
      weA_q       <= 1'b0;
      weB_q       <= 1'b0;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      lenA_q      <= '0;
      lenB_q      <= '0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      en_ram_q    <= 1'b0;
      weA_q       <= 1'b0;
      weB_q       <= 1'b0;
      load_done_q <= (state_q == DONE);
      load_err_q  <= (state_q == ERR);
      if (start) begin
        // A byte offered alongside start is dropped; the new load begins clean.
        state_q     <= LOAD_A;
        rx_ready_q  <= 1'b1;
        lenA_q      <= '0;
        lenB_q      <= '0;
        load_done_q <= 1'b0;
        load_err_q  <= 1'b0;
      end else begin
        case (state_q)
          LOAD_A, LOAD_B: begin
            if (accept_d) begin
              if (sym_d != 3'b000) begin
                if (len_cur_d == LenMax) begin
                  state_q    <= ERR;
                  rx_ready_q <= 1'b0;
                end else begin
                  en_ram_q  <= 1'b1;
                  din_ram_q <= sym_d;
                  if (sel_b_d) begin
                    weB_q    <= 1'b1;
                    addr_b_q <= len_inc_d;
                    lenB_q   <= len_inc_d;
                  end else begin
                    weA_q    <= 1'b1;
                    addr_a_q <= len_inc_d;
                    lenA_q   <= len_inc_d;
                  end
                end
              end else if (is_term_d) begin
                if (len_cur_d == '0) begin
                  state_q    <= ERR;
                  rx_ready_q <= 1'b0;
                end else if (sel_b_d) begin
                  state_q    <= DONE;
                  rx_ready_q <= 1'b0;
                end else begin
                  state_q <= LOAD_B;
                end
              end else if (!is_cr_d) begin
                state_q    <= ERR;
                rx_ready_q <= 1'b0;
              end
            end
          end
          IDLE, DONE, ERR: begin
            rx_ready_q <= 1'b0;
          end
          default: begin
            state_q    <= IDLE;
            rx_ready_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rx_ready  = rx_ready_q;
  assign din_ram   = din_ram_q;
  assign en_ram    = en_ram_q;
  assign weA       = weA_q;
  assign weB       = weB_q;
  assign addr_dinA = addr_a_q;
  assign addr_dinB = addr_b_q;
  assign lenA      = lenA_q;
  assign lenB      = lenB_q;
  assign load_done = load_done_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_seq_stream_loader.sv
// Directed bench for seq_stream_loader: vector table of byte streams plus hand-written corner sequences.
module tb_seq_stream_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] rx_data;
  logic       rx_valid;

  logic       rx_ready, en_ram, weA, weB, load_done, load_err;
  logic [2:0] din_ram;
  logic [8:0] addr_dinA, addr_dinB, lenA, lenB;

  logic       rx_ready4, en_ram4, weA4, weB4, load_done4, load_err4;
  logic [2:0] din_ram4;
  logic [3:0] addr_dinA4, addr_dinB4, lenA4, lenB4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_stream_loader dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .din_ram(din_ram), .en_ram(en_ram), .weA(weA), .weB(weB),
    .addr_dinA(addr_dinA), .addr_dinB(addr_dinB), .lenA(lenA), .lenB(lenB),
    .load_done(load_done), .load_err(load_err)
  );

  seq_stream_loader #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready4), .din_ram(din_ram4), .en_ram(en_ram4), .weA(weA4), .weB(weB4),
    .addr_dinA(addr_dinA4), .addr_dinB(addr_dinB4), .lenA(lenA4), .lenB(lenB4),
    .load_done(load_done4), .load_err(load_err4)
  );

  // write log entries: {en, weA, weB, addr, din}
  logic [14:0] wq[$];
  logic [14:0] wq4[$];

  always @(negedge clk) begin
    if (en_ram || weA || weB)
      wq.push_back({en_ram, weA, weB, (weB ? addr_dinB : addr_dinA), din_ram});
    if (en_ram4 || weA4 || weB4)
      wq4.push_back({en_ram4, weA4, weB4, 5'b0, (weB4 ? addr_dinB4 : addr_dinA4), din_ram4});
  end

  typedef struct {
    string stim;
    string exp_a;
    string exp_b;
    bit    done;
    bit    err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] code_of(input byte c);
    case (c)
      "A": return 3'b001;
      "C": return 3'b010;
      "G": return 3'b011;
      "T": return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = s[i];
    end
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [14:0] e;
    logic [8:0]  a9;
    int          na, nb;

    vecs.push_back('{stim: "ACGT;GA\n", exp_a: "ACGT", exp_b: "GA", done: 1'b1, err: 1'b0});
    vecs.push_back('{stim: "AC\r\nT;",  exp_a: "AC",   exp_b: "T",  done: 1'b1, err: 1'b0});
    vecs.push_back('{stim: ";",         exp_a: "",     exp_b: "",   done: 1'b0, err: 1'b1});
    vecs.push_back('{stim: "G;T;",      exp_a: "G",    exp_b: "T",  done: 1'b1, err: 1'b0});
    vecs.push_back('{stim: "AXG",       exp_a: "A",    exp_b: "",   done: 1'b0, err: 1'b1});
    vecs.push_back('{stim: "A;;",       exp_a: "A",    exp_b: "",   done: 1'b0, err: 1'b1});
    vecs.push_back('{stim: "TT;C\rG\n", exp_a: "TT",   exp_b: "CG", done: 1'b1, err: 1'b0});
`ifdef SEQ_LOADER_LOWERCASE_EN
    vecs.push_back('{stim: "acg;t;",    exp_a: "ACG",  exp_b: "T",  done: 1'b1, err: 1'b0});
`else
    vecs.push_back('{stim: "acg;t;",    exp_a: "",     exp_b: "",   done: 1'b0, err: 1'b1});
`endif

    rst = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {rx_ready, en_ram, weA, weB, din_ram, addr_dinA, addr_dinB, lenA, lenB, load_done, load_err}, 64'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_ready", rx_ready, 0);

    for (int v = 0; v < vecs.size(); v++) begin
      wq.delete();
      pulse_start();
      chk($sformatf("v%0d ready_after_start", v), rx_ready, 1);
      send_str(vecs[v].stim);
      if (vecs[v].done) chk($sformatf("v%0d done_not_early", v), load_done, 0);
      @(negedge clk);
      if (vecs[v].done) chk($sformatf("v%0d done_two_cycles", v), load_done, 1);
      @(negedge clk);
      na = vecs[v].exp_a.len();
      nb = vecs[v].exp_b.len();
      chk($sformatf("v%0d lenA", v), lenA, 64'(na));
      chk($sformatf("v%0d lenB", v), lenB, 64'(nb));
      chk($sformatf("v%0d done", v), load_done, 64'(vecs[v].done));
      chk($sformatf("v%0d err", v), load_err, 64'(vecs[v].err));
      chk($sformatf("v%0d ready_low", v), rx_ready, 0);
      chk($sformatf("v%0d write_count", v), 64'(wq.size()), 64'(na + nb));
      for (int i = 0; i < na + nb && i < wq.size(); i++) begin
        if (i < na) begin
          a9 = 9'(i + 1);
          e  = {1'b1, 1'b1, 1'b0, a9, code_of(vecs[v].exp_a[i])};
        end else begin
          a9 = 9'(i - na + 1);
          e  = {1'b1, 1'b0, 1'b1, a9, code_of(vecs[v].exp_b[i - na])};
        end
        chk($sformatf("v%0d write%0d", v, i), wq[i], e);
      end
    end

    // N=4 instance: fifth symbol overflows A
    wq4.delete();
    pulse_start();
    send_str("ACGTA");
    repeat (2) @(negedge clk);
    chk("n4 lenA", lenA4, 4);
    chk("n4 err", load_err4, 1);
    chk("n4 ready_low", rx_ready4, 0);
    chk("n4 write_count", 64'(wq4.size()), 4);
    if (wq4.size() == 4) chk("n4 last_write", wq4[3], {1'b1, 1'b1, 1'b0, 9'd4, 3'b100});

    // start arriving with a byte while a write is still pending
    wq.delete();
    pulse_start();
    @(negedge clk); rx_valid = 1'b1; rx_data = "A";
    @(negedge clk); rx_data = "C";
    @(negedge clk); start = 1'b1; rx_data = "G";
    chk("restart pending_write", {en_ram, weA, addr_dinA, din_ram}, {1'b1, 1'b1, 9'd2, 3'b010});
    @(negedge clk); start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    chk("restart lenA_cleared", lenA, 0);
    chk("restart byte_dropped", en_ram, 0);
    chk("restart ready", rx_ready, 1);
    send_str("T;A;");
    repeat (2) @(negedge clk);
    chk("restart lens", {lenA, lenB}, {9'd1, 9'd1});
    chk("restart done", {load_done, load_err}, 2'b10);
    chk("restart write_count", 64'(wq.size()), 4);
    if (wq.size() == 4) chk("restart write2", wq[2], {1'b1, 1'b1, 1'b0, 9'd1, 3'b100});

    // reset mid-load
    pulse_start();
    send_str("AC");
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("midreset outputs",
        {rx_ready, en_ram, weA, weB, din_ram, addr_dinA, addr_dinB, lenA, lenB, load_done, load_err}, 64'h0);
    wq.delete();
    send_str("G;T;");
    repeat (2) @(negedge clk);
    chk("midreset ignored", {rx_ready, lenA, lenB, load_done, load_err}, 64'h0);
    chk("midreset no_writes", 64'(wq.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_stream_loader.md
Name: seq_stream_loader

Overview:
- Writer side of the datapath's sequence-RAM load port.
- Accepts a byte stream of ASCII nucleotides over a valid/ready handshake and encodes each to a 3-bit symbol.
- Drives din_ram/en_ram/weA/weB/addr_dinA/addr_dinB to fill sequence A, then sequence B.
- Reports the two lengths and a done/error status to the top-level controller before alignment starts.

Parameters:
N, 128, maximum symbols per sequence
BitAddr, $clog2(N+1), address index width; address ports are BitAddr+1 bits, matching the datapath

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low
start  in  1  one-cycle pulse; arms a new load, clears lengths and status
rx_data  in  8  ASCII byte from the upstream source (UART RX or bench)
rx_valid  in  1  rx_data is valid
rx_ready  out  1  loader accepts a byte this cycle
din_ram  out  3  encoded symbol to write
en_ram  out  1  RAM enable, high on every write cycle
weA  out  1  write strobe, sequence A RAM
weB  out  1  write strobe, sequence B RAM
addr_dinA  out  BitAddr+1  write address, sequence A
addr_dinB  out  BitAddr+1  write address, sequence B
lenA  out  BitAddr+1  symbols stored in A
lenB  out  BitAddr+1  symbols stored in B
load_done  out  1  both sequences loaded successfully; level signal
load_err  out  1  load aborted; level signal

Behaviour:
- Reset (rst==0 at a clk edge): state IDLE; every output 0, including lenA, lenB and the addresses. Reset takes effect mid-load; a partially written RAM is not cleared.
- Encoding: 'A'->3'b001, 'C'->3'b010, 'G'->3'b011, 'T'->3'b100; 3'b000 is reserved (gap).
- Terminators: 0x0A ('\n') and 0x3B (';').
- 0x0D is consumed and ignored: no write, no state change.
- Any other byte is invalid.
- Handshake: a byte transfers when rx_valid && rx_ready.
  - rx_ready is high in LOAD_A and LOAD_B, low in all other states.
  - Throughput is one byte per cycle; there are no bubbles.
- Write timing: registered, 1-cycle latency.
  - The cycle after a valid symbol is accepted, en_ram=1 and weA (or weB)=1 for exactly one cycle.
  - din_ram carries the encoded symbol.
  - The address equals the new length; symbols occupy addresses 1..len, and address 0 is never written.
  - Outside write cycles, en_ram/weA/weB are 0. din_ram and the addresses hold their last value.
- States:
  - IDLE: start -> LOAD_A.
  - LOAD_A:
    - symbol -> write A, lenA+1.
    - terminator with lenA>0 -> LOAD_B.
    - terminator with lenA==0 -> ERR.
    - invalid byte -> ERR.
    - symbol while lenA==N -> ERR, no write.
  - LOAD_B: same rules using B / lenB; a valid terminator -> DONE.
  - DONE: load_done=1, rx_ready=0; hold until start or reset.
  - ERR: load_err=1, rx_ready=0; lenA/lenB hold their values for diagnosis; hold until start.
- start in any state, including mid-load: next cycle state=LOAD_A, lenA=lenB=0, load_done=load_err=0.
  - Any byte presented in the same cycle as start is not accepted; rx_ready is evaluated on the old state but the transfer is discarded.
  - A write pending from the previous cycle still completes.
- Simultaneous transitions: on the terminator cycle, the last symbol's write (accepted the previous cycle) still completes in the cycle the state changes.
- Load_done/load_err are mutually exclusive.

Optional Feature:
- Macro: SEQ_LOADER_LOWERCASE_EN.
- Defined: 'a','c','g','t' are accepted and encode identically to their uppercase forms.
- Undefined: lowercase letters are invalid bytes and drive the FSM to ERR.

Test Plan:
- start; stream "ACGT;GA\n" with rx_valid held high -> weA pulses at addr 1..4 with din 001,010,011,100; weB at addr 1..2 with 011,001; lenA=4, lenB=2; load_done=1 two cycles after '\n'.
- start; "AC\r\nT;" -> CR ignored; lenA=2, lenB=1, load_done=1, no write for 0x0D.
- start; ";" -> load_err=1, lenA=0, no en_ram pulse; then start; "G;T;" -> load_done=1, load_err=0.
- N=4 build; start; "ACGTA" -> 4 writes to A, 5th symbol causes ERR with no write; lenA=4, rx_ready=0.
- start; "AXG" -> ERR after 'X' with lenA=1; with SEQ_LOADER_LOWERCASE_EN, "acg;t;" -> load_done=1, lenA=3; without the macro -> load_err after 'a'.
- rst=0 after "AC" mid-load -> next cycle all outputs 0, rx_ready=0, IDLE; bytes ignored until start.
